// File: rtl/rv32_alu_decode.sv
// RV32 ALU-op decoder feeding a 2-entry skid FIFO (head register + skid register).
// Decode is combinational on the input word; only the head entry drives the outputs.
module rv32_alu_decode (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_opsel,
  output logic [31:0] code_bus,
  output logic [31:0] pc,
  output logic        enable,
  output logic [4:0]  rd_addr,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic        illegal,
  output logic [7:0]  illegal_cnt
);

  typedef struct packed {
    logic [3:0]  opsel;
    logic        en;
    logic        ill;
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t     dec, head, skid;
  logic [1:0] count;
  logic       accept, consume;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  always_comb begin
    dec       = '0;
    dec.instr = in_instr;
    dec.pc    = in_pc;
    dec.ill   = 1'b1;
    case (in_instr[6:0])
      7'b0110011: begin
        if (in_instr[31:25] == 7'b0000000) begin
          dec.ill = 1'b0;
          case (in_instr[14:12])
            3'b000:  dec.opsel = 4'd0;
            3'b111:  dec.opsel = 4'd2;
            3'b110:  dec.opsel = 4'd3;
            3'b100:  dec.opsel = 4'd4;
            3'b010:  dec.opsel = 4'd5;
            3'b011:  dec.opsel = 4'd6;
            default: dec.ill   = 1'b1;
          endcase
        end else if (in_instr[31:25] == 7'b0100000 && in_instr[14:12] == 3'b000) begin
          dec.ill   = 1'b0;
          dec.opsel = 4'd1;
        end
      end
      7'b0010011: begin
        dec.ill = 1'b0;
        case (in_instr[14:12])
          3'b000:  dec.opsel = 4'd7;
          3'b111:  dec.opsel = 4'd9;
          3'b110:  dec.opsel = 4'd10;
          3'b100:  dec.opsel = 4'd11;
          3'b010:  dec.opsel = 4'd12;
          3'b011:  dec.opsel = 4'd13;
          default: dec.ill   = 1'b1;
        endcase
      end
      7'b0110111: begin dec.ill = 1'b0; dec.opsel = 4'd14; end
      7'b0010111: begin dec.ill = 1'b0; dec.opsel = 4'd15; end
      default: dec.ill = 1'b1;
    endcase
    // illegal entries present opsel 0 with enable low
    if (dec.ill) dec.opsel = 4'd0;
    dec.en = ~dec.ill;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count       <= 2'd0;
      head        <= '0;
      skid        <= '0;
      illegal_cnt <= 8'd0;
    end else begin
      // a flush-dropped input never counts as accepted
      if (accept && !flush && dec.ill && illegal_cnt != 8'hFF)
        illegal_cnt <= illegal_cnt + 8'd1;
      if (flush) count <= 2'd0;
      else begin
        case (count)
          2'd0: if (accept) begin head <= dec; count <= 2'd1; end
          2'd1: begin
            if (accept && consume) head <= dec;
            else if (accept) begin skid <= dec; count <= 2'd2; end
            else if (consume) count <= 2'd0;
          end
          2'd2: if (consume) begin head <= skid; count <= 2'd1; end
          default: count <= 2'd0;
        endcase
      end
    end
  end

  assign alu_opsel = head.opsel;
  assign enable    = head.en;
  assign illegal   = head.ill;
  assign code_bus  = head.instr;
  assign pc        = head.pc;
  assign rd_addr   = head.instr[11:7];
  assign rs1_addr  = head.instr[19:15];
  assign rs2_addr  = head.instr[24:20];

endmodule

// File: tb/tb_rv32_alu_decode.sv
// Directed bench for rv32_alu_decode with an in-order scoreboard of expected head entries.
module tb_rv32_alu_decode;
  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic        in_ready, out_valid, enable, illegal;
  logic [31:0] in_instr, in_pc, code_bus, pc;
  logic [3:0]  alu_opsel;
  logic [4:0]  rd_addr, rs1_addr, rs2_addr;
  logic [7:0]  illegal_cnt;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [3:0]  opsel;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  int          checks = 0, errors = 0;
  int          exp_cnt = 0;
  bit          t;

  rv32_alu_decode dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .alu_opsel(alu_opsel), .code_bus(code_bus), .pc(pc),
    .enable(enable), .rd_addr(rd_addr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, score handshakes, advance past the rising edge.
  task automatic cycle(output bit took);
    exp_t e;
    @(negedge clk);
    chk("in_ready_vs_occupancy", in_ready, sb.size() < 2);
    chk("out_valid_vs_occupancy", out_valid, sb.size() > 0);
    if (out_valid) chk("opsel_not_8", alu_opsel == 4'd8, 0);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_output", 1, 0);
      else begin
        e = sb.pop_front();
        chk("opsel", alu_opsel, e.opsel);
        chk("enable", enable, !e.ill);
        chk("illegal", illegal, e.ill);
        chk("code_bus", code_bus, e.instr);
        chk("pc", pc, e.pc);
        chk("rd", rd_addr, e.instr[11:7]);
        chk("rs1", rs1_addr, e.instr[19:15]);
        chk("rs2", rs2_addr, e.instr[24:20]);
      end
    end
    took = in_valid && in_ready;
    if (took && !flush) begin
      sb.push_back(cur);
      if (cur.ill && exp_cnt < 255) exp_cnt++;
    end
    @(posedge clk); #1;
    if (flush) sb.delete();
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] p, input int op, input bit ill);
    in_valid  = 1'b1;
    in_instr  = ins;
    in_pc     = p;
    cur.instr = ins;
    cur.pc    = p;
    cur.opsel = 4'(op);
    cur.ill   = ill;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] p, input int op, input bit ill);
    bit tk = 0;
    drive(ins, p, op, ill);
    for (int i = 0; i < 20 && !tk; i++) cycle(tk);
    if (!tk) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit tk;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 4; i++) cycle(tk);
    chk("drained", sb.size(), 0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_cnt"}, illegal_cnt, 0);
    chk({tag, "_opsel"}, alu_opsel, 0);
    chk({tag, "_code_bus"}, code_bus, 0);
    chk({tag, "_pc"}, pc, 0);
    chk({tag, "_en_ill"}, {enable, illegal}, 0);
    chk({tag, "_regs"}, {rd_addr, rs1_addr, rs2_addr}, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Back-to-back ADD/SUB, one per cycle.
    out_ready = 1'b1;
    send(32'h002081B3, 32'h0, 0, 0);
    send(32'h402081B3, 32'h4, 1, 0);
    drain();

    send(32'hFFF00293, 32'h8, 7, 0);
    send(32'h123450B7, 32'hC, 14, 0);
    send(32'h00001117, 32'h100, 15, 0);
    send(32'h00109093, 32'h104, 0, 1);
    drain();
    chk("illegal_cnt_one", illegal_cnt, 1);

    // Remaining R/I encodings and a spread of illegal forms.
    send({7'b0, 5'd2, 5'd1, 3'b111, 5'd3, 7'b0110011}, 32'h200, 2, 0);
    send({7'b0, 5'd4, 5'd5, 3'b110, 5'd6, 7'b0110011}, 32'h204, 3, 0);
    send({7'b0, 5'd7, 5'd8, 3'b100, 5'd9, 7'b0110011}, 32'h208, 4, 0);
    send({7'b0, 5'd10, 5'd11, 3'b010, 5'd12, 7'b0110011}, 32'h20C, 5, 0);
    send({7'b0, 5'd13, 5'd14, 3'b011, 5'd15, 7'b0110011}, 32'h210, 6, 0);
    send({12'h7FF, 5'd1, 3'b111, 5'd2, 7'b0010011}, 32'h214, 9, 0);
    send({12'h800, 5'd3, 3'b110, 5'd4, 7'b0010011}, 32'h218, 10, 0);
    send({12'h001, 5'd5, 3'b100, 5'd6, 7'b0010011}, 32'h21C, 11, 0);
    send({12'h002, 5'd7, 3'b010, 5'd8, 7'b0010011}, 32'h220, 12, 0);
    send({12'h003, 5'd9, 3'b011, 5'd10, 7'b0010011}, 32'h224, 13, 0);
    send({7'b0100000, 5'd2, 5'd1, 3'b111, 5'd3, 7'b0110011}, 32'h228, 0, 1);
    send({7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011}, 32'h22C, 0, 1);
    send({7'b0, 5'd2, 5'd1, 3'b001, 5'd3, 7'b0110011}, 32'h230, 0, 1);
    send({12'h000, 5'd1, 3'b101, 5'd2, 7'b0010011}, 32'h234, 0, 1);
    send(32'h0000006F, 32'h238, 0, 1);
    drain();
    chk("illegal_cnt_mix", illegal_cnt, 6);

    // Backpressure: two accepted, third held with the head stable.
    out_ready = 1'b0;
    send(32'h00310233, 32'h300, 0, 0);
    send(32'h40418333, 32'h304, 1, 0);
    drive(32'h0062F3B3, 32'h308, 2, 0);
    cycle(t); chk("third_held_1", t, 0); chk("head_stable_1", code_bus, 32'h00310233);
    cycle(t); chk("third_held_2", t, 0); chk("head_stable_2", pc, 32'h300);
    out_ready = 1'b1;
    send(32'h0062F3B3, 32'h308, 2, 0);
    drain();

    // Flush at full with a pending input, then flush of an accepted illegal.
    out_ready = 1'b0;
    send(32'h00310233, 32'h400, 0, 0);
    send(32'h40418333, 32'h404, 1, 0);
    drive(32'h0062F3B3, 32'h408, 2, 0);
    flush = 1'b1;
    cycle(t);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    drive(32'h00109093, 32'h40C, 0, 1);
    flush = 1'b1;
    cycle(t);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_drop_out_valid", out_valid, 0);
    chk("flush_drop_cnt", illegal_cnt, 6);
    drain();

    // Saturation of the illegal counter.
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) send(32'h00109093, 32'(i * 4), 0, 1);
    drain();
    chk("illegal_cnt_sat", illegal_cnt, 255);
    chk("illegal_cnt_model", illegal_cnt, exp_cnt);

    // Asynchronous reset with two entries held.
    out_ready = 1'b0;
    send(32'h002081B3, 32'h500, 0, 0);
    send(32'h402081B3, 32'h504, 1, 0);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk_zero_outputs("async_reset");
    sb.delete(); exp_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
